tcm_axi_stream_loader: RTL and testbench
========================================

Name: tcm_axi_stream_loader

Overview:
- Upstream boot/DMA loader for the TCM AXI slave port.
- Accepts a 32-bit valid/ready word stream (e.g. from a UART or SPI boot agent) and writes it to consecutive TCM addresses using AXI4 INCR write bursts.
- Drives only the AW/W/B channels of the TCM AXI slave. AR/R are left to other masters.

Parameters:
MAX_BURST, 16, maximum beats per burst; power of two, 1..16.
AXI_ID, 4'd0, value driven on axi_awid_o and expected back on axi_bid_i.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  start request; sampled only in IDLE
addr_i  in  32  destination byte address; bits [1:0] ignored (forced 0)
words_i  in  16  number of 32-bit words to write
in_valid_i  in  1  stream word valid
in_data_i  in  32  stream word
in_ready_o  out  1  stream word accepted when in_valid_i && in_ready_o
busy_o  out  1  transfer in progress
done_o  out  1  one-cycle pulse at transfer completion
error_o  out  1  sticky error; cleared by next accepted start_i
axi_awvalid_o  out  1  AW valid
axi_awaddr_o  out  32  burst start address
axi_awid_o  out  4  = AXI_ID
axi_awlen_o  out  8  beats-1
axi_awburst_o  out  2  = 2'b01 (INCR)
axi_awready_i  in  1  AW ready
axi_wvalid_o  out  1  W valid
axi_wdata_o  out  32  W data (registered)
axi_wstrb_o  out  4  = 4'hF
axi_wlast_o  out  1  last beat of burst
axi_wready_i  in  1  W ready
axi_bvalid_i  in  1  B valid
axi_bresp_i  in  2  B response
axi_bid_i  in  4  B id
axi_bready_o  out  1  B ready

Behaviour:
- Reset: state IDLE; all outputs 0, except constant axi_awid_o=AXI_ID, axi_awburst_o=2'b01, axi_wstrb_o=4'hF.
- Reset mid-transfer aborts immediately: no done_o pulse, error_o=0.
- FSM states: IDLE, ADDR, DATA, RESP, DONE.
- IDLE:
  - start_i latches addr_q={addr_i[31:2],2'b00} and remain_q=words_i; clears error_o; sets busy_o.
  - words_i==0 -> DONE; otherwise -> ADDR.
  - busy_o rises the cycle after start_i; axi_awvalid_o rises the same cycle.
- Burst sizing, computed on entry to ADDR: beats = min(remain_q, MAX_BURST, 1024-addr_q[11:2]). Bursts never cross a 4 KB boundary.
- ADDR:
  - axi_awvalid_o=1; axi_awaddr_o=addr_q and axi_awlen_o=beats-1, both stable until axi_awready_i.
  - On handshake -> DATA; beat counters cleared.
- DATA:
  - in_ready_o = (accepted < beats) && (!axi_wvalid_o || axi_wready_i).
  - Accepted word loads axi_wdata_o and sets axi_wvalid_o.
  - axi_wlast_o=1 when the held beat index == beats-1.
  - axi_wvalid_o is held, with wdata stable, until axi_wready_i; it is never withdrawn. If no new word is accepted on a W handshake, it is cleared.
  - After the wlast handshake -> RESP. in_ready_o=0 outside DATA.
- RESP:
  - axi_bready_o=1.
  - On axi_bvalid_i: set error_o if axi_bresp_i!=2'b00 or axi_bid_i!=AXI_ID.
  - Update addr_q+=beats*4 and remain_q-=beats (32-bit address arithmetic, wraps mod 2^32).
  - remain_q==0 -> DONE; else -> ADDR.
- Errors do not abort the transfer.
- DONE: done_o=1 for exactly one cycle; busy_o=0 from the next cycle; -> IDLE.
- start_i while busy is ignored.
- Data ordering: words appear on W in stream acceptance order. Total W beats == words_i exactly.

Test Plan:
1. addr_i=0x100, words_i=4, stream always valid, slave always ready -> one AW (awaddr=0x100, awlen=3); 4 W beats with wlast on the 4th; done_o pulses one cycle after the bvalid handshake; error_o=0.
2. addr_i=0x0, words_i=40, MAX_BURST=16 -> three bursts at 0x000/0x040/0x080 with awlen=15/15/7; data 0..39 delivered in order.
3. addr_i=0xFF8, words_i=6 -> burst awaddr=0xFF8 awlen=1, then awaddr=0x1000 awlen=3; no burst crosses 0x1000.
4. Random in_valid_i gaps and random axi_wready_i/axi_awready_i stalls over words_i=37 -> axi_wvalid_o never drops before its handshake; wdata stable while stalled; stream order preserved; exactly 37 beats.
5. words_i=0 -> no AXI activity; busy_o high one cycle, then done_o pulse. Separately, bresp=2'b10 on burst 1 of 2 -> error_o=1, second burst still issued, done_o pulses; next start_i clears error_o.
6. Assert rst_i during DATA beat 3 of 8 -> all valids/ready/busy_o=0 immediately; no done_o; a subsequent start_i runs a clean transfer.

Source files
------------

// File: rtl/tcm_axi_stream_loader.sv
// tcm_axi_stream_loader: writes a 32-bit valid/ready word stream into TCM using AXI4 INCR write bursts
module tcm_axi_stream_loader #(
  parameter int unsigned MAX_BURST = 16,
  parameter logic [3:0]  AXI_ID    = 4'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic [15:0] words_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  output logic        in_ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        axi_awvalid_o,
  output logic [31:0] axi_awaddr_o,
  output logic [3:0]  axi_awid_o,
  output logic [7:0]  axi_awlen_o,
  output logic [1:0]  axi_awburst_o,
  input  logic        axi_awready_i,
  output logic        axi_wvalid_o,
  output logic [31:0] axi_wdata_o,
  output logic [3:0]  axi_wstrb_o,
  output logic        axi_wlast_o,
  input  logic        axi_wready_i,
  input  logic        axi_bvalid_i,
  input  logic [1:0]  axi_bresp_i,
  input  logic [3:0]  axi_bid_i,
  output logic        axi_bready_o
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_al, wdata_q;
  logic [15:0] remain_q;
  logic [4:0]  acc_q, idx_q;
  logic [16:0] to_bnd, cap, beats;
  logic        wvalid_q, error_q;
  // burst length only depends on registers that are frozen from ADDR until the B handshake
  assign addr_al = addr_i & ~32'd3;
  assign to_bnd  = 17'd1024 - 17'(addr_q[11:2]);
  assign cap     = (17'(remain_q) < 17'(MAX_BURST)) ? 17'(remain_q) : 17'(MAX_BURST);
  assign beats   = (cap < to_bnd) ? cap : to_bnd;
  assign axi_awaddr_o  = addr_q;
  assign axi_awid_o    = AXI_ID;
  assign axi_awburst_o = 2'b01;
  assign axi_wstrb_o   = 4'hF;
  assign axi_wvalid_o  = wvalid_q;
  assign axi_wdata_o   = wdata_q;
  assign error_o       = error_q;
  // state register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  // next state and channel control outputs
  always_comb begin
    state_d       = state_q;
    in_ready_o    = 1'b0;
    busy_o        = state_q != IDLE;
    done_o        = state_q == DONE;
    axi_awvalid_o = state_q == ADDR;
    axi_awlen_o   = (state_q == ADDR) ? 8'(beats - 17'd1) : 8'd0;
    axi_bready_o  = state_q == RESP;
    axi_wlast_o   = wvalid_q && (17'(idx_q) == beats - 17'd1);
    case (state_q)
      IDLE: if (start_i) state_d = (words_i == 16'd0) ? DONE : ADDR;
      ADDR: if (axi_awready_i) state_d = DATA;
      DATA: begin
        in_ready_o = (17'(acc_q) < beats) && (!wvalid_q || axi_wready_i);
        if (axi_wlast_o && axi_wready_i) state_d = RESP;
      end
      RESP: if (axi_bvalid_i) state_d = (remain_q == 16'(beats)) ? DONE : ADDR;
      default: state_d = IDLE;
    endcase
  end
  // transfer bookkeeping and the registered W beat
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      addr_q   <= '0;
      remain_q <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      wvalid_q <= 1'b0;
      wdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && start_i) begin
        addr_q   <= addr_al;
        remain_q <= words_i;
        error_q  <= 1'b0;
      end
      if (state_q == ADDR && axi_awready_i) begin
        acc_q <= '0;
        idx_q <= '0;
      end
      if (in_ready_o && in_valid_i) begin
        wdata_q  <= in_data_i;
        wvalid_q <= 1'b1;
        idx_q    <= acc_q;
        acc_q    <= acc_q + 5'd1;
      end else if (wvalid_q && axi_wready_i) wvalid_q <= 1'b0;
      if (state_q == RESP && axi_bvalid_i) begin
        addr_q   <= addr_q + {13'd0, beats, 2'b00};
        remain_q <= remain_q - 16'(beats);
        if (axi_bresp_i != 2'b00 || axi_bid_i != AXI_ID) error_q <= 1'b1;
      end
    end
endmodule

// File: tb/tb_tcm_axi_stream_loader.sv
// tb_tcm_axi_stream_loader: directed bench with a stream source and an AXI write slave model
module tb_tcm_axi_stream_loader;
  logic        clk = 1'b0, rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [15:0] words_i = '0;
  logic        in_valid_i = 1'b0;
  logic [31:0] in_data_i = '0;
  logic        in_ready_o, busy_o, done_o, error_o;
  logic        axi_awvalid_o, axi_wvalid_o, axi_wlast_o, axi_bready_o;
  logic [31:0] axi_awaddr_o, axi_wdata_o;
  logic [3:0]  axi_awid_o, axi_wstrb_o;
  logic [7:0]  axi_awlen_o;
  logic [1:0]  axi_awburst_o;
  logic        axi_awready_i = 1'b0, axi_wready_i = 1'b0, axi_bvalid_i = 1'b0;
  logic [1:0]  axi_bresp_i = 2'b00;
  logic [3:0]  axi_bid_i = 4'd0;
  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, done_cyc = -1, b_cyc = -1;
  int src_left = 0, b_pend = 0, b_idx = 0, err_burst = -1;
  int beat_in = 0, aw_w_idx = 0, wlast_bad = 0, stall_bad = 0;
  logic [31:0] next_word = '0;
  bit gaps = 1'b0, stalls = 1'b0;
  logic [31:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  logic [31:0] w_data_q[$];
  bit          pw_stall = 1'b0, paw_stall = 1'b0;
  logic [31:0] pw_data = '0, paw_addr = '0;
  logic [7:0]  paw_len = '0;
  logic        pw_last = 1'b0;

  tcm_axi_stream_loader dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .addr_i(addr_i), .words_i(words_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .axi_awvalid_o(axi_awvalid_o), .axi_awaddr_o(axi_awaddr_o), .axi_awid_o(axi_awid_o),
    .axi_awlen_o(axi_awlen_o), .axi_awburst_o(axi_awburst_o), .axi_awready_i(axi_awready_i),
    .axi_wvalid_o(axi_wvalid_o), .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o),
    .axi_wlast_o(axi_wlast_o), .axi_wready_i(axi_wready_i),
    .axi_bvalid_i(axi_bvalid_i), .axi_bresp_i(axi_bresp_i), .axi_bid_i(axi_bid_i),
    .axi_bready_o(axi_bready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // drive source/slave inputs on the falling edge, then observe the handshakes due at the next rising edge
  always @(negedge clk) begin
    cyc++;
    in_valid_i    = src_left > 0 && (!gaps || $urandom_range(0, 2) != 0);
    in_data_i     = next_word;
    axi_awready_i = !stalls || $urandom_range(0, 2) == 0;
    axi_wready_i  = !stalls || $urandom_range(0, 1) == 0;
    axi_bvalid_i  = b_pend > 0;
    axi_bresp_i   = (b_idx == err_burst) ? 2'b10 : 2'b00;
    #1;
    if (rst_i) begin
      pw_stall  = 1'b0;
      paw_stall = 1'b0;
    end else begin
      if (pw_stall && (!axi_wvalid_o || axi_wdata_o !== pw_data || axi_wlast_o !== pw_last)) stall_bad++;
      if (paw_stall && (!axi_awvalid_o || axi_awaddr_o !== paw_addr || axi_awlen_o !== paw_len)) stall_bad++;
      pw_stall  = axi_wvalid_o && !axi_wready_i;
      pw_data   = axi_wdata_o;
      pw_last   = axi_wlast_o;
      paw_stall = axi_awvalid_o && !axi_awready_i;
      paw_addr  = axi_awaddr_o;
      paw_len   = axi_awlen_o;
      if (in_valid_i && in_ready_o) begin
        src_left--;
        next_word++;
      end
      if (axi_awvalid_o && axi_awready_i) begin
        aw_addr_q.push_back(axi_awaddr_o);
        aw_len_q.push_back(axi_awlen_o);
      end
      if (axi_wvalid_o && axi_wready_i) begin
        w_data_q.push_back(axi_wdata_o);
        if (aw_w_idx >= aw_len_q.size() || axi_wlast_o != (beat_in == int'(aw_len_q[aw_w_idx]))) wlast_bad++;
        if (axi_wlast_o) begin
          beat_in = 0;
          aw_w_idx++;
          b_pend++;
        end else beat_in++;
      end
      if (axi_bvalid_i && axi_bready_o) begin
        b_pend--;
        b_idx++;
        b_cyc = cyc;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic prep(input logic [15:0] n, input logic [31:0] base, input bit g, input bit s, input int eb);
    aw_addr_q.delete();
    aw_len_q.delete();
    w_data_q.delete();
    aw_w_idx = 0; beat_in = 0; b_idx = 0; b_pend = 0; wlast_bad = 0; stall_bad = 0;
    err_burst = eb; gaps = g; stalls = s; next_word = base; src_left = n;
  endtask

  task automatic run(input logic [31:0] a, input logic [15:0] n, input logic [31:0] base,
                     input bit g, input bit s, input int eb);
    int d0, i;
    prep(n, base, g, s, eb);
    d0 = done_cnt;
    @(negedge clk);
    start_i = 1'b1; addr_i = a; words_i = n;
    @(negedge clk);
    start_i = 1'b0;
    #2;
    chk("busy_rise", busy_o, 1);
    chk("err_clear", error_o, 0);
    i = 0;
    while (done_cnt == d0 && i < 3000) begin
      @(negedge clk);
      #2;
      i++;
    end
    @(negedge clk);
    #2;
    chk("done_count", done_cnt - d0, 1);
    chk("idle_after", {busy_o, done_o}, 0);
  endtask

  task automatic exp_aw(input int i, input logic [31:0] a, input logic [7:0] l);
    chk($sformatf("aw%0d_addr", i), aw_addr_q.size() > i ? aw_addr_q[i] : 32'hDEADBEEF, a);
    chk($sformatf("aw%0d_len", i), aw_len_q.size() > i ? 32'(aw_len_q[i]) : 32'hDEADBEEF, 32'(l));
  endtask

  task automatic verify(input int n, input logic [31:0] base, input int nb);
    chk("aw_count", aw_addr_q.size(), nb);
    chk("b_count", b_idx, nb);
    chk("w_count", w_data_q.size(), n);
    for (int i = 0; i < w_data_q.size() && i < n; i++) chk("w_data", w_data_q[i], base + i);
    chk("wlast", wlast_bad, 0);
    chk("stall_hold", stall_bad, 0);
  endtask

  initial begin
    int d0, i;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_ctrl", {busy_o, done_o, error_o, axi_awvalid_o, axi_wvalid_o, in_ready_o, axi_bready_o, axi_wlast_o}, 0);
    chk("rst_awlen", axi_awlen_o, 0);
    chk("rst_awaddr", axi_awaddr_o, 0);
    chk("rst_const", {axi_awid_o, axi_awburst_o, axi_wstrb_o}, {4'd0, 2'b01, 4'hF});
    @(negedge clk);
    rst_i = 1'b0;
    // single burst, check AW presented together with busy
    prep(4, 32'hA0, 0, 0, -1);
    @(negedge clk);
    start_i = 1'b1; addr_i = 32'h103; words_i = 16'd4;
    @(negedge clk);
    start_i = 1'b0;
    #2;
    chk("t1_busy", busy_o, 1);
    chk("t1_awvalid", axi_awvalid_o, 1);
    chk("t1_awaddr", axi_awaddr_o, 32'h100);
    chk("t1_awlen", axi_awlen_o, 3);
    i = 0;
    while (done_cnt == 0 && i < 500) begin
      @(negedge clk);
      #2;
      i++;
    end
    chk("t1_done", done_cnt, 1);
    chk("t1_done_lat", done_cyc - b_cyc, 1);
    chk("t1_err", error_o, 0);
    exp_aw(0, 32'h100, 3);
    verify(4, 32'hA0, 1);
    // multi-burst split at MAX_BURST
    run(32'h0, 40, 32'h0, 0, 0, -1);
    exp_aw(0, 32'h000, 15);
    exp_aw(1, 32'h040, 15);
    exp_aw(2, 32'h080, 7);
    verify(40, 32'h0, 3);
    // 4 KB boundary split
    run(32'hFF8, 6, 32'h300, 0, 0, -1);
    exp_aw(0, 32'hFF8, 1);
    exp_aw(1, 32'h1000, 3);
    verify(6, 32'h300, 2);
    // random source gaps and slave stalls
    run(32'hF00, 37, 32'h1000, 1, 1, -1);
    exp_aw(0, 32'hF00, 15);
    exp_aw(1, 32'hF40, 15);
    exp_aw(2, 32'hF80, 4);
    verify(37, 32'h1000, 3);
    // zero-length transfer
    run(32'h200, 0, 32'h0, 0, 0, -1);
    chk("t5_no_aw", aw_addr_q.size(), 0);
    chk("t5_no_w", w_data_q.size(), 0);
    // error response on first of two bursts
    run(32'h40, 20, 32'h500, 0, 0, 0);
    chk("t5_err_set", error_o, 1);
    exp_aw(0, 32'h40, 15);
    exp_aw(1, 32'h80, 3);
    verify(20, 32'h500, 2);
    run(32'h80, 1, 32'h600, 0, 0, -1);
    chk("t5_err_gone", error_o, 0);
    // reset in the middle of a burst
    prep(8, 32'h700, 0, 0, -1);
    @(negedge clk);
    start_i = 1'b1; addr_i = 32'h200; words_i = 16'd8;
    @(negedge clk);
    start_i = 1'b0;
    i = 0;
    while (w_data_q.size() < 2 && i < 200) begin
      @(negedge clk);
      #2;
      i++;
    end
    chk("t6_reach", w_data_q.size() >= 2, 1);
    @(negedge clk);
    #3;
    d0 = done_cnt;
    rst_i = 1'b1;
    #1;
    chk("t6_abort", {axi_awvalid_o, axi_wvalid_o, in_ready_o, busy_o, axi_bready_o, done_o, error_o}, 0);
    src_left = 0;
    b_pend = 0;
    @(negedge clk);
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_idle", busy_o, 0);
    run(32'h300, 3, 32'h800, 0, 0, -1);
    exp_aw(0, 32'h300, 2);
    verify(3, 32'h800, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
